// File: rtl/sprite_mem_loader.sv
// Streams IMG_W x IMG_H pixel bytes into sprite memory in raster order;
// the memory address port is shared with the renderer's read address.
module sprite_mem_loader #(
   parameter int unsigned IMG_W = 344,
   parameter int unsigned IMG_H = 95
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [14:0] rd_addr,
   output logic [14:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        loading,
   output logic        done
);

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned X_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned Y_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [ADDR_W-1:0]   r_mem_waddr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_mem_we;
   logic                r_loading;
   logic                r_done;
   logic                w_xfer;
   logic                w_start_ok;
   logic                w_last_px;

   assign in_ready   = (r_state == S_LOAD);
   assign w_xfer     = in_valid & in_ready;
   assign w_start_ok = (r_state == S_IDLE) & start & ~abort;
   assign w_last_px  = (r_x == X_LAST) & (r_y == Y_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start_ok) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (abort)                      w_state_nxt = S_IDLE;
            else if (w_xfer && w_last_px)   w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Raster counters; wr_addr tracks y*IMG_W+x incrementally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x       <= '0;
         r_y       <= '0;
         r_wr_addr <= '0;
      end else if (w_start_ok) begin
         r_x       <= '0;
         r_y       <= '0;
         r_wr_addr <= '0;
      end else if (w_xfer) begin
         if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + Y_W'(1);
         end else begin
            r_x <= r_x + X_W'(1);
         end
         r_wr_addr <= r_wr_addr + ADDR_W'(1);
      end
   end

   // Write port lags the handshake by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_we    <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_loading   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_mem_we  <= w_xfer;
         r_loading <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         if (w_xfer) begin
            r_mem_waddr <= r_wr_addr;
            r_mem_wdata <= in_data;
         end
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign mem_addr  = r_mem_we ? r_mem_waddr : rd_addr;
   assign loading   = r_loading;
   assign done      = r_done;

endmodule

// File: tb/tb_sprite_mem_loader.sv
// Directed bench for sprite_mem_loader: reset, gaps, abort, async reset, full load.
module tb_sprite_mem_loader;

   localparam int unsigned IMG_W = 344;
   localparam int unsigned IMG_H = 95;
   localparam int unsigned NPIX  = IMG_W * IMG_H;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] rd_addr;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        loading;
   logic        done;

   int n_vec  = 0;
   int n_miss = 0;

   sprite_mem_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rd_addr   (rd_addr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .loading   (loading),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix(input int i);
      logic [31:0] v;
      v = i * 7 + (i >> 8);
      return v[7:0];
   endfunction

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_loading", 32'(loading), 32'd1);
      check("start_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic do_abort_idle();
      in_valid = 1'b0;
      abort    = 1'b1;
      tick();
      abort    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      in_data = 8'h00; in_valid = 1'b0; rd_addr = 15'h1234;
      #12;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_loading", 32'(loading), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_addr_pass", 32'(mem_addr), 32'h1234);
      rd_addr = 15'h0ABC;
      #1;
      check("rst_addr_pass2", 32'(mem_addr), 32'h0ABC);
      tick();
      rst = 1'b0;
      tick();

      // start with abort in IDLE stays idle
      start = 1'b1; abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      tick();
      start = 1'b0; abort = 1'b0;
      check("sa_loading", 32'(loading), 32'd0);
      check("sa_ready", 32'(in_ready), 32'd0);
      tick();
      check("sa_we", 32'(mem_we), 32'd0);
      check("sa_addr", 32'(mem_addr), 32'h0ABC);
      in_valid = 1'b0;

      // valid gap 1,0,0,1
      rd_addr = 15'h1234;
      do_start();
      in_valid = 1'b1; in_data = 8'hA1; tick();
      check("gap_we0", 32'(mem_we), 32'd1);
      check("gap_addr0", 32'(mem_addr), 32'd0);
      check("gap_data0", 32'(mem_wdata), 32'hA1);
      in_valid = 1'b0; in_data = 8'hB2; tick();
      check("gap_we1", 32'(mem_we), 32'd0);
      check("gap_rd1", 32'(mem_addr), 32'h1234);
      in_data = 8'hC3; tick();
      check("gap_we2", 32'(mem_we), 32'd0);
      check("gap_rd2", 32'(mem_addr), 32'h1234);
      in_valid = 1'b1; in_data = 8'hD4; tick();
      check("gap_we3", 32'(mem_we), 32'd1);
      check("gap_addr3", 32'(mem_addr), 32'd1);
      check("gap_data3", 32'(mem_wdata), 32'hD4);
      do_abort_idle();
      check("gap_end_loading", 32'(loading), 32'd0);

      // abort after 100 transfers
      do_start();
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1; in_data = pix(i + 3); tick();
         check("ab_we", 32'(mem_we), 32'd1);
         check("ab_addr", 32'(mem_addr), 32'(i));
         check("ab_data", 32'(mem_wdata), 32'(pix(i + 3)));
      end
      in_valid = 1'b0; abort = 1'b1; tick();
      abort = 1'b0;
      check("ab_ready", 32'(in_ready), 32'd0);
      check("ab_we_after", 32'(mem_we), 32'd0);
      check("ab_done", 32'(done), 32'd0);
      check("ab_loading", 32'(loading), 32'd0);
      // restart writes from 0; transfer coincident with abort still writes once
      do_start();
      in_valid = 1'b1; in_data = 8'h5A; tick();
      check("rs_addr", 32'(mem_addr), 32'd0);
      check("rs_data", 32'(mem_wdata), 32'h5A);
      abort = 1'b1; in_data = 8'h66; tick();
      abort = 1'b0;
      check("xab_we", 32'(mem_we), 32'd1);
      check("xab_addr", 32'(mem_addr), 32'd1);
      check("xab_data", 32'(mem_wdata), 32'h66);
      check("xab_ready", 32'(in_ready), 32'd0);
      tick();
      check("xab_we_next", 32'(mem_we), 32'd0);
      check("xab_done", 32'(done), 32'd0);
      in_valid = 1'b0;

      // async reset mid-LOAD
      do_start();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = pix(i); tick();
      end
      check("ar_pre_we", 32'(mem_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_we", 32'(mem_we), 32'd0);
      check("ar_loading", 32'(loading), 32'd0);
      check("ar_ready", 32'(in_ready), 32'd0);
      check("ar_wdata", 32'(mem_wdata), 32'd0);
      check("ar_addr", 32'(mem_addr), 32'h1234);
      tick();
      check("ar_we_hold", 32'(mem_we), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      do_start();
      in_valid = 1'b1; in_data = 8'h77; tick();
      check("ar_restart_addr", 32'(mem_addr), 32'd0);
      do_abort_idle();

      // full image load
      do_start();
      for (int i = 0; i < NPIX; i++) begin
         in_valid = 1'b1; in_data = pix(i); tick();
         check("fl_we", 32'(mem_we), 32'd1);
         check("fl_addr", 32'(mem_addr), 32'(i));
         check("fl_data", 32'(mem_wdata), 32'(pix(i)));
         if (i == IMG_W) check("fl_row_wrap", 32'(mem_addr), 32'd344);
         if (i < NPIX - 1) check("fl_no_done", 32'(done), 32'd0);
      end
      check("fl_done", 32'(done), 32'd1);
      check("fl_loading_done", 32'(loading), 32'd1);
      check("fl_ready_done", 32'(in_ready), 32'd0);
      tick();
      check("fl_done_clr", 32'(done), 32'd0);
      check("fl_idle_loading", 32'(loading), 32'd0);
      check("fl_idle_we", 32'(mem_we), 32'd0);
      check("fl_idle_addr", 32'(mem_addr), 32'h1234);
      in_valid = 1'b0;
      tick();
      check("fl_idle_done", 32'(done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/sprite_mem_loader.md
SPRITE_MEM_LOADER -- requirements
Module: sprite_mem_loader

Interface
Parameters:
REQ-001 The block SHALL have parameter IMG_W, default 344, sprite width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 95, sprite height in lines; IMG_W*IMG_H SHALL not exceed 32768.

Ports:
REQ-003 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, load-request pulse.
REQ-006 The block SHALL have port abort, input, 1, cancels a load in progress.
REQ-007 The block SHALL have port in_data, input, 8, pixel byte in RRRGGGBB format.
REQ-008 The block SHALL have port in_valid, input, 1, in_data is valid.
REQ-009 The block SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-010 The block SHALL have port rd_addr, input, 15, read address from the sprite renderer.
REQ-011 The block SHALL have port mem_addr, output, 15, address to the sprite memory.
REQ-012 The block SHALL have port mem_wdata, output, 8, write data to the sprite memory.
REQ-013 The block SHALL have port mem_we, output, 1, write enable to the sprite memory.
REQ-014 The block SHALL have port loading, output, 1, high while a load is in progress.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse when a full image is written.

Function
REQ-016 The block SHALL implement a three-state FSM with states IDLE, LOAD and DONE.
REQ-017 In IDLE, start=1 and abort=0 SHALL move the FSM to LOAD and clear x, y and wr_addr to 0.
REQ-018 In IDLE, abort SHALL win over a simultaneous start; the FSM SHALL stay in IDLE.
REQ-019 in_ready SHALL be 1 only in LOAD, combinationally decoded from state.
REQ-020 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-021 On a transfer, the next cycle SHALL have mem_we=1, mem_wdata=in_data and mem_addr=wr_addr as sampled at the transfer (one-cycle registered latency).
REQ-022 On a transfer, x SHALL increment; at x=IMG_W-1 x SHALL wrap to 0 and y SHALL increment.
REQ-023 wr_addr SHALL increment by 1 per transfer and SHALL always equal y*IMG_W+x; no multiplier is required.
REQ-024 A transfer at x=IMG_W-1, y=IMG_H-1 SHALL move the FSM to DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1; the final write SHALL occur in that same cycle; the FSM SHALL then return to IDLE.
REQ-026 mem_we SHALL be 0 in every cycle not following a transfer, with no writes without a handshake.
REQ-027 mem_addr SHALL equal the registered write address when mem_we=1, and SHALL equal rd_addr combinationally otherwise.
REQ-028 loading SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-029 start SHALL be ignored in LOAD and DONE.
REQ-030 abort in LOAD SHALL return the FSM to IDLE on the next edge.
REQ-031 A transfer coincident with abort SHALL still produce its single write; no further writes SHALL follow, and done SHALL not pulse.
REQ-032 in_valid gaps SHALL stall counters without side effects.
REQ-033 in_data SHALL be ignored when in_ready=0.

Reset
REQ-034 When rst=1, the block SHALL force IDLE asynchronously with x=0, y=0, wr_addr=0, mem_we=0, mem_wdata=0, done=0, loading=0 and in_ready=0.
REQ-035 While rst=1, mem_addr SHALL pass through rd_addr.
REQ-036 Reset asserted mid-LOAD SHALL discard progress; a new start SHALL restart from address 0.
REQ-037 Release of rst SHALL be synchronized externally; the block SHALL not require a first-cycle special case.

Verification
REQ-038 The bench SHALL cover a full load: start, then 32680 bytes with in_valid held at 1 -> writes to addresses 0..32679 in order, done pulses once one cycle after the last handshake, FSM returns to IDLE.
REQ-039 The bench SHALL cover row wrap: after 344 transfers -> the 345th write has mem_addr=344 (x=0, y=1).
REQ-040 The bench SHALL cover a valid gap: in_valid toggling 1,0,0,1 -> exactly two writes at consecutive addresses, with mem_addr=rd_addr on non-write cycles.
REQ-041 The bench SHALL cover abort: abort after 100 transfers -> 100 writes, no done, in_ready=0 next cycle; a restart writes address 0 first.
REQ-042 The bench SHALL cover async reset: rst pulsed mid-cycle during LOAD -> outputs clear immediately without waiting for clk, and mem_we stays 0.
REQ-043 The bench SHALL cover start+abort in IDLE -> FSM remains in IDLE with loading=0.
